// File: rtl/nibble_serial_pkg.sv
// nibble_serial_pkg: shared types and helpers for the nibble-serial adder.
package nibble_serial_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NIBBLE_W = 4;
    function automatic int clog2(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/csk_slice4.sv
// csk_slice4: 4-bit carry-skip adder slice.
module csk_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_rip
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end
    assign s = p ^ c[3:0];
    // Skip term bypasses the ripple when every bit propagates.
    assign co = c[4] | (&p & ci);
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add via one 4-bit carry-skip slice, LSB nibble first.
// Define NIBBLE_SERIAL_SUB_EN to add a sub port computing A-B.
module nibble_serial_adder_ctrl
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = clog2(NIB);

    if (WIDTH % NIBBLE_W != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] b_cap;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             cout_r;
    logic             c_cap;
    logic             accept;
    logic             last;
    logic [3:0]       s;
    logic             co;

    csk_slice4 u_slice (.a(a_sh[3:0]), .b(b_sh[3:0]), .ci(carry), .s(s), .co(co));

`ifdef NIBBLE_SERIAL_SUB_EN
    assign b_cap = sub ? ~B : B;
    assign c_cap = sub | cin;
`else
    assign b_cap = B;
    assign c_cap = cin;
`endif

    assign accept  = state == IDLE && in_valid;
    assign last    = idx == IW'(NIB - 1);
    // New nibble enters at the top; after NIB shifts the LSB nibble sits at bit 0.
    assign sum_nxt = WIDTH'({s, sum_r} >> NIBBLE_W);
    assign sum     = sum_r;
    assign cout    = cout_r;

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nxt;

    always_comb
        state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) :
                    (out_ready ? IDLE : DONE);

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= b_cap;
            carry <= c_cap;
            idx   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            sum_r <= sum_nxt;
            carry <= co;
            idx   <= idx + IW'(1);
            if (last)
                cout_r <= co;
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: randomized self-checking bench against an arithmetic reference.
// Define NIBBLE_SERIAL_SUB_EN to also exercise subtraction.
module tb_nibble_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sub = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub(sub),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(a),
        .B(b),
        .cin(cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = x;
        r = r + y;
        r = r + c;
        return r;
    endfunction

    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    endtask

    task automatic test_table();
        logic [W-1:0] ta[5] = '{16'hFFFF, 16'h0F0F, 16'hFFFF, 16'h0000, 16'h8000};
        logic [W-1:0] tb[5] = '{16'h0001, 16'hF0F0, 16'hFFFF, 16'h0000, 16'h8000};
        logic         tc[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W:0]   e;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            e = ref_add(ta[i], tb[i], tc[i]);
            start(ta[i], tb[i], tc[i]);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL run_in_ready[%0d]: got %b want 0", i, in_ready); end
            wait_done(lat);
            total++; if (lat !== NIB) begin bad++; $display("FAIL latency[%0d]: got %0d want %0d", i, lat, NIB); end
            total++; if ({cout, sum} !== e) begin bad++; $display("FAIL table_result[%0d]: got %b_%h want %b_%h", i, cout, sum, e[W], e[W-1:0]); end
            take();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL table_release[%0d]: got out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start(16'h1234, 16'h1111, 1'b0);
        wait_done(lat);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h2345 || cout !== 1'b0) begin
                bad++; $display("FAIL hold[%0d]: got ov=%b ir=%b %b_%h want 1 0 0_2345", i, out_valid, in_ready, cout, sum);
            end
        end
        in_valid = 1'b0;
        total++; if ({cout, sum} !== 17'h02345) begin bad++; $display("FAIL hold_result: got %b_%h want 0_2345", cout, sum); end
        take();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_release: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start(16'hAAAA, 16'h5555, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0) begin
            bad++; $display("FAIL mid_reset: got ir=%b ov=%b sum=%h want 1 0 0000", in_ready, out_valid, sum);
        end
        repeat (6) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_no_result: got %b want 0", out_valid); end
        start(16'h0003, 16'h0004, 1'b0);
        wait_done(lat);
        total++; if (lat !== NIB || {cout, sum} !== 17'h00007) begin
            bad++; $display("FAIL after_reset: got lat=%0d %b_%h want %0d 0_0007", lat, cout, sum, NIB);
        end
        take();
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        int n_acc = 0, n_res = 0, cyc = 0, last_acc = -1;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        while (n_res < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            in_valid = n_acc < 20;
            if (out_valid === 1'b1) begin
                e = q.size() > 0 ? q.pop_front() : 'x;
                total++; if ({cout, sum} !== e) begin bad++; $display("FAIL b2b_result[%0d]: got %b_%h want %b_%h", n_res, cout, sum, e[W], e[W-1:0]); end
                n_res++;
            end
            if (in_ready === 1'b1 && in_valid) begin
                if (last_acc >= 0) begin
                    total++; if (cyc - last_acc !== NIB + 2) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", n_acc, cyc - last_acc, NIB + 2); end
                end
                last_acc = cyc;
                q.push_back(ref_add(a, b, cin));
                n_acc++;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom_range(0, 1));
            end
        end
        total++; if (n_res !== 20) begin bad++; $display("FAIL b2b_count: got %0d want 20", n_res); end
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

`ifdef NIBBLE_SERIAL_SUB_EN
    task automatic test_sub();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] es;
        logic         ec;
        int           lat;
        sub = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = i == 0 ? 16'h0005 : i == 1 ? 16'h0007 : W'($urandom);
            y = i == 0 ? 16'h0007 : i == 1 ? 16'h0005 : W'($urandom);
            es = x - y;
            ec = x >= y;
            start(x, y, 1'($urandom_range(0, 1)));
            wait_done(lat);
            total++; if (sum !== es || cout !== ec) begin bad++; $display("FAIL sub[%0d]: got %b_%h want %b_%h", i, cout, sum, ec, es); end
            take();
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_table();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef NIBBLE_SERIAL_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
